icache_direct_mapped: RTL and testbench

- Direct-mapped, read-only instruction cache between the naive_mips ibus port and an instruction memory port with a read/waitrequest handshake.
- Hits return data in the same cycle with no stall. A miss stalls the CPU while the cache refills one whole line from memory, one word at a time.
- Also provides an uncached bypass and a per-index invalidate, which is driven by the CPU's icache-invalidate output.

---
 rtl/icache_direct_mapped_if.sv | 27 ++
 rtl/icache_direct_mapped.sv | 144 ++++++++++++++
 tb/tb_icache_direct_mapped.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_mapped_if.sv
// CPU fetch port, invalidate strobe and instruction-memory read port of the icache.
// The slave modport is the cache's view; the master modport drives requests and memory replies.
interface icache_direct_mapped_if;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic        ibus_uncached;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;
    logic        icache_inv;
    logic [31:0] icache_inv_addr;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_rddata;
    logic        mem_waitrequest;

    modport slave (
        input  ibus_address, ibus_read, ibus_uncached, icache_inv, icache_inv_addr,
        input  mem_rddata, mem_waitrequest,
        output ibus_rddata, ibus_stall, mem_address, mem_read
    );

    modport master (
        output ibus_address, ibus_read, ibus_uncached, icache_inv, icache_inv_addr,
        output mem_rddata, mem_waitrequest,
        input  ibus_rddata, ibus_stall, mem_address, mem_read
    );
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line refill on miss,
// uncached bypass and per-index invalidate.
module icache_direct_mapped #(
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned INDEX_WIDTH = 6
) (
    input logic                  clk,
    input logic                  rst,
    icache_direct_mapped_if.slave bus
);
    localparam int unsigned WORD_W   = $clog2(LINE_WORDS);
    localparam int unsigned OFFSET_W = WORD_W + 2;
    localparam int unsigned TAG_W    = 32 - OFFSET_W - INDEX_WIDTH;
    localparam int unsigned LINES    = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {StIdle, StRefill, StBypass, StResp} state_e;

    state_e                 state_q;
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [31:0]            data_mem [LINES][LINE_WORDS];
    logic [LINES-1:0]       valid_q;
    logic [INDEX_WIDTH-1:0] fill_idx_q;
    logic [TAG_W-1:0]       fill_tag_q;
    logic [WORD_W-1:0]      cnt_q;
    logic                   pend_q;
    logic [INDEX_WIDTH-1:0] pend_idx_q;
    logic [31:0]            byp_data_q;
    logic [31:0]            mem_addr_q;
    logic                   mem_read_q;

    logic [INDEX_WIDTH-1:0] req_idx;
    logic [WORD_W-1:0]      req_word;
    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0] inv_idx;
    logic [INDEX_WIDTH-1:0] clr_idx;
    logic [WORD_W-1:0]      cnt_inc;
    logic                   hit;
    logic                   mem_done;
    logic                   last_word;
    logic                   clr_any;
    logic                   unused_bits;

    assign req_idx   = bus.ibus_address[OFFSET_W +: INDEX_WIDTH];
    assign req_word  = bus.ibus_address[2 +: WORD_W];
    assign req_tag   = bus.ibus_address[31 -: TAG_W];
    assign inv_idx   = bus.icache_inv_addr[OFFSET_W +: INDEX_WIDTH];
    assign cnt_inc   = cnt_q + WORD_W'(1);
    assign mem_done  = mem_read_q & ~bus.mem_waitrequest;
    assign last_word = (cnt_q == WORD_W'(LINE_WORDS - 1));
    assign unused_bits = ^{bus.ibus_address[1:0], bus.icache_inv_addr[31:OFFSET_W+INDEX_WIDTH],
                           bus.icache_inv_addr[OFFSET_W-1:0]};

    // A pulse arriving on the returning cycle supersedes the one already pending.
    assign clr_any = bus.icache_inv | pend_q;
    assign clr_idx = bus.icache_inv ? inv_idx : pend_idx_q;

    assign hit = (state_q == StIdle) & bus.ibus_read & ~bus.ibus_uncached & valid_q[req_idx]
               & (tag_mem[req_idx] == req_tag);

    assign bus.ibus_stall  = bus.ibus_read & ~hit & (state_q != StResp);
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = mem_addr_q;

    always_comb begin
        bus.ibus_rddata = '0;
        if (hit) begin
            bus.ibus_rddata = data_mem[req_idx][req_word];
        end else if (state_q == StResp) begin
            bus.ibus_rddata = byp_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            byp_data_q <= '0;
            mem_addr_q <= '0;
            mem_read_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.icache_inv) valid_q[inv_idx] <= 1'b0;
                    if (bus.ibus_read && !hit) begin
                        mem_read_q <= 1'b1;
                        if (bus.ibus_uncached) begin
                            mem_addr_q <= {bus.ibus_address[31:2], 2'b00};
                            state_q    <= StBypass;
                        end else begin
                            mem_addr_q <= {bus.ibus_address[31:OFFSET_W], OFFSET_W'(0)};
                            fill_idx_q <= req_idx;
                            fill_tag_q <= req_tag;
                            cnt_q      <= '0;
                            state_q    <= StRefill;
                        end
                    end
                end
                StRefill: begin
                    if (bus.icache_inv) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= inv_idx;
                    end
                    if (mem_done) begin
                        data_mem[fill_idx_q][cnt_q] <= bus.mem_rddata;
                        if (last_word) begin
                            tag_mem[fill_idx_q] <= fill_tag_q;
                            valid_q[fill_idx_q] <= 1'b1;
                            if (clr_any) valid_q[clr_idx] <= 1'b0;
                            pend_q     <= 1'b0;
                            mem_read_q <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            cnt_q      <= cnt_inc;
                            // Upper bits stay fixed, so the fill wraps inside the line.
                            mem_addr_q <= {mem_addr_q[31:OFFSET_W], cnt_inc, 2'b00};
                        end
                    end
                end
                StBypass: begin
                    if (bus.icache_inv) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= inv_idx;
                    end
                    if (mem_done) begin
                        byp_data_q <= bus.mem_rddata;
                        mem_read_q <= 1'b0;
                        state_q    <= StResp;
                    end
                end
                StResp: begin
                    if (clr_any) valid_q[clr_idx] <= 1'b0;
                    pend_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed bench for icache_direct_mapped: memory returns word = address with a
// programmable number of wait cycles per word.
module tb_icache_direct_mapped;
    logic clk = 1'b0;
    logic rst;

    icache_direct_mapped_if bus ();

    icache_direct_mapped #(
        .LINE_WORDS (4),
        .INDEX_WIDTH(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_cfg = 0;
    int          wait_cnt = 0;
    int          n_txn    = 0;
    int          stab_err = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] addr_log [256];

    assign bus.mem_rddata      = bus.mem_address;
    assign bus.mem_waitrequest = bus.mem_read && (wait_cnt < wait_cfg);

    always @(posedge clk) begin
        if (bus.mem_read && !bus.mem_waitrequest) begin
            wait_cnt <= 0;
            addr_log[8'(n_txn)] <= bus.mem_address;
            n_txn <= n_txn + 1;
        end else if (bus.mem_read) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        if (prev_wait && bus.mem_read && bus.mem_address != prev_addr) stab_err <= stab_err + 1;
        prev_wait <= bus.mem_read && bus.mem_waitrequest;
        prev_addr <= bus.mem_address;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that consumes the fetch.
    task automatic fetch(input logic [31:0] a, input logic unc, output int stalls,
                         output logic [31:0] d);
        bus.ibus_address  = a;
        bus.ibus_uncached = unc;
        bus.ibus_read     = 1'b1;
        stalls = 0;
        d      = 32'hDEAD_DEAD;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.ibus_stall) begin
                d = bus.ibus_rddata;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.ibus_read = 1'b0;
    endtask

    task automatic run_fetch(input string tag, input logic [31:0] a, input logic unc,
                             input int exp_stalls, input int exp_txn,
                             input logic [31:0] exp_first, input logic [31:0] exp_last);
        int          base;
        int          stalls;
        logic [31:0] d;
        base = n_txn;
        fetch(a, unc, stalls, d);
        check_eq({tag, "_data"}, d, a);
        check_eq({tag, "_stalls"}, stalls, exp_stalls);
        check_eq({tag, "_txns"}, n_txn - base, exp_txn);
        if (exp_txn > 0) begin
            check_eq({tag, "_first_addr"}, addr_log[8'(base)], exp_first);
            check_eq({tag, "_last_addr"}, addr_log[8'(base + exp_txn - 1)], exp_last);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        bus.ibus_address    = '0;
        bus.ibus_read       = 1'b0;
        bus.ibus_uncached   = 1'b0;
        bus.icache_inv      = 1'b0;
        bus.icache_inv_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_mem_read", bus.mem_read, 0);
        check_eq("rst_mem_addr", bus.mem_address, 0);
        check_eq("rst_stall", bus.ibus_stall, 0);
        check_eq("rst_rddata", bus.ibus_rddata, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss, then a hit in the same line with no memory traffic.
        run_fetch("cold", 32'h8000_0000, 1'b0, 5, 4, 32'h8000_0000, 32'h8000_000C);
        run_fetch("hit", 32'h8000_000C, 1'b0, 0, 0, 0, 0);

        // Conflict on index 0.
        run_fetch("conflict", 32'h8000_0400, 1'b0, 5, 4, 32'h8000_0400, 32'h8000_040C);
        run_fetch("refetch", 32'h8000_0000, 1'b0, 5, 4, 32'h8000_0000, 32'h8000_000C);

        // Three wait cycles on every word.
        wait_cfg = 3;
        run_fetch("wait", 32'h8000_0014, 1'b0, 17, 4, 32'h8000_0010, 32'h8000_001C);
        check_eq("wait_addr_stable", stab_err, 0);
        wait_cfg = 0;

        // Uncached bypass never fills.
        run_fetch("uncached", 32'hBFC0_0000, 1'b1, 2, 1, 32'hBFC0_0000, 32'hBFC0_0000);
        run_fetch("uncached2", 32'hBFC0_0000, 1'b1, 2, 1, 32'hBFC0_0000, 32'hBFC0_0000);

        // Line base at the top of memory wraps inside the line.
        run_fetch("wrap", 32'hFFFF_FFF8, 1'b0, 5, 4, 32'hFFFF_FFF0, 32'hFFFF_FFFC);

        // Idle invalidate: same-cycle lookup still hits, following cycle misses.
        bus.ibus_address    = 32'h8000_0000;
        bus.ibus_uncached   = 1'b0;
        bus.ibus_read       = 1'b1;
        bus.icache_inv      = 1'b1;
        bus.icache_inv_addr = 32'h8000_0000;
        @(negedge clk);
        check_eq("inv_same_cycle_stall", bus.ibus_stall, 0);
        check_eq("inv_same_cycle_data", bus.ibus_rddata, 32'h8000_0000);
        @(posedge clk);
        #1;
        bus.icache_inv = 1'b0;
        @(negedge clk);
        check_eq("inv_next_cycle_stall", bus.ibus_stall, 1);
        bus.ibus_read = 1'b0;
        @(posedge clk);
        #1;
        run_fetch("inv_idle", 32'h8000_0004, 1'b0, 5, 4, 32'h8000_0000, 32'h8000_000C);

        // Invalidate of the line being refilled: the CPU re-misses after the first fill.
        fork
            run_fetch("inv_refill", 32'h8000_0020, 1'b0, 10, 8, 32'h8000_0020, 32'h8000_002C);
            begin
                @(posedge clk);
                #1;
                bus.icache_inv      = 1'b1;
                bus.icache_inv_addr = 32'h8000_0024;
                @(posedge clk);
                #1;
                bus.icache_inv      = 1'b0;
            end
        join

        // Reset during the second refill word aborts the fill.
        bus.ibus_address  = 32'h8000_0030;
        bus.ibus_uncached = 1'b0;
        bus.ibus_read     = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("rst_mid_addr", bus.mem_address, 32'h8000_0034);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_mem_read", bus.mem_read, 0);
        check_eq("rst_mid_mem_addr", bus.mem_address, 0);
        rst           = 1'b0;
        bus.ibus_read = 1'b0;
        @(posedge clk);
        #1;
        run_fetch("after_rst", 32'h8000_0030, 1'b0, 5, 4, 32'h8000_0030, 32'h8000_003C);
        run_fetch("after_rst_hit", 32'h8000_0038, 1'b0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
